// File: rtl/fetch_unit.sv
// Single-buffer instruction fetch: one outstanding memory request, one buffered word.
// Define FETCH_PERF_EN to enable the fetch/bubble performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INS,
  output logic        clr,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [29:0] pc_w, req_w;
  logic [31:0] ins_reg;
  logic        valid;
  logic        consume, issue, load;
  logic        unused_ok;

  // Addresses are kept as word indices, so byte offsets simply disappear.
  assign unused_ok = ^redirect_pc[1:0];

  assign consume = valid & ~stall;
  assign issue   = (state == IDLE) & ~redirect & (~valid | consume);
  assign load    = (state == WAIT) & imem_ack & ~redirect;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (imem_ack)      state_nxt = IDLE;
        else if (redirect) state_nxt = DROP;
      end
      DROP: if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_w    <= RESET_PC[31:2];
      req_w   <= RESET_PC[31:2];
      valid   <= 1'b0;
      ins_reg <= 32'h0;
      ins_pc  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (issue) req_w <= pc_w;
      // Redirect wins over both a fresh load and consumption of the buffer.
      if (redirect) begin
        pc_w  <= redirect_pc[31:2];
        valid <= 1'b0;
      end else if (load) begin
        pc_w  <= pc_w + 30'd1;
        valid <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end
      if (load) begin
        ins_reg <= imem_rdata;
        ins_pc  <= {req_w, 2'b00};
      end
    end
  end

  assign imem_req  = (state == WAIT) | (state == DROP);
  assign imem_addr = {req_w, 2'b00};
  assign INS       = valid ? ins_reg : 32'h0;
  assign ins_valid = valid;
  assign clr       = redirect;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (load)            fetch_cnt  <= fetch_cnt + 32'd1;
      if (!valid && !stall) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule
